// File: rtl/moore_seq_pkg.sv
// Shared types for the Moore FSM sequencing controller.
// Controller state encoding and the 2-bit FSM state constants.
package moore_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } ctrl_state_t;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

endpackage

// File: rtl/moore_seq_bitgen.sv
// Pattern shift register and bit counter for the sequencing controller.
// Ports: clock, reset; load latches pattern; clear/step drive the bit
// counter; shift moves the register left; msb, first_bit, last_bit out.
module moore_seq_bitgen #(
    parameter int PAT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             clear,
    input  logic             shift,
    input  logic             step,
    output logic             msb,
    output logic             first_bit,
    output logic             last_bit
);

    localparam int BW = $clog2(PAT_W);
    localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

    logic [PAT_W-1:0] sr;
    logic [BW-1:0]    cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= pattern;
        end else if (shift) begin
            sr <= {sr[PAT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset || load || clear) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign msb       = sr[PAT_W-1];
    assign first_bit = (cnt == '0);
    assign last_bit  = (cnt == LAST);

endmodule

// File: rtl/moore_seq_controller.sv
// Drives a latched pattern MSB-first into a 2-bit Moore FSM and reports
// the final FSM state and the number of post-bit samples equal to S3.
// Ports: clock, reset (sync, active-high), start, pattern -> busy, done,
// final_state, s3_count, fsm_reset_n, x_out; y_in is the FSM state.
// Build option MOORE_SEQ_HITCOUNT_EN: builds the S3 hit counter;
// when undefined s3_count is tied to zero.
module moore_seq_controller
    import moore_seq_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = $clog2(PAT_W + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic [1:0]       final_state,
    output logic [CNT_W-1:0] s3_count,
    output logic             fsm_reset_n,
    output logic             x_out,
    input  logic [1:0]       y_in
);

    ctrl_state_t state;
    ctrl_state_t next_state;

    logic accept;
    logic shift_en;
    logic step_en;
    logic msb;
    logic first_bit;
    logic last_bit;

    moore_seq_bitgen #(
        .PAT_W(PAT_W)
    ) u_bitgen (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .pattern  (pattern),
        .clear    (state == LOAD),
        .shift    (shift_en),
        .step     (step_en),
        .msb      (msb),
        .first_bit(first_bit),
        .last_bit (last_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // x_out is registered, so the register shifts on every edge that
    // enters a SHIFT cycle: the LOAD edge presents the MSB.
    always_comb begin
        busy     = (state == LOAD) || (state == SHIFT) || (state == DRAIN);
        done     = (state == DONE);
        accept   = (state == IDLE) && start;
        shift_en = (state == LOAD) || ((state == SHIFT) && !last_bit);
        step_en  = (state == SHIFT) && !last_bit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_out       <= 1'b0;
            fsm_reset_n <= 1'b0;
            final_state <= S0;
        end else begin
            x_out       <= shift_en ? msb : 1'b0;
            fsm_reset_n <= (next_state != LOAD);
            if (state == DRAIN) begin
                final_state <= y_in;
            end
        end
    end

`ifdef MOORE_SEQ_HITCOUNT_EN
    // y_in lags x_out by one cycle, so the first SHIFT cycle still shows
    // the post-reset S0 and is skipped; DRAIN supplies the last sample.
    logic             sample;
    logic [CNT_W-1:0] hits;

    assign sample = ((state == SHIFT) && !first_bit) || (state == DRAIN);

    always_ff @(posedge clock) begin
        if (reset || accept) begin
            hits <= '0;
        end else if (sample && (y_in == S3)) begin
            hits <= hits + 1'b1;
        end
    end

    assign s3_count = hits;
`else
    logic unused_first_bit;
    assign unused_first_bit = first_bit;
    assign s3_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_controller.sv
// Directed bench for moore_seq_controller with a behavioural Moore FSM.
// Ports of the DUT are all driven/observed from this module.
`timescale 1ns/1ps
module tb_moore_seq_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic       busy;
    logic       done;
    logic [1:0] final_state;
    logic [3:0] s3_count;
    logic       fsm_reset_n;
    logic       x_out;
    logic [1:0] y_in = 2'b00;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    moore_seq_controller #(
        .PAT_W(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .busy       (busy),
        .done       (done),
        .final_state(final_state),
        .s3_count   (s3_count),
        .fsm_reset_n(fsm_reset_n),
        .x_out      (x_out),
        .y_in       (y_in)
    );

    // x=0: S0->S1->S3->S0 ; x=1: S0 holds, S1->S2, S2 holds, S3 holds
    function automatic logic [1:0] fsm_next(input logic [1:0] s,
                                            input logic x);
        case (s)
            2'b00:   return x ? 2'b00 : 2'b01;
            2'b01:   return x ? 2'b10 : 2'b11;
            2'b10:   return x ? 2'b10 : 2'b00;
            default: return x ? 2'b11 : 2'b00;
        endcase
    endfunction

    always @(posedge clock) begin
        y_in <= !fsm_reset_n ? 2'b00 : fsm_next(y_in, x_out);
    end

    function automatic logic [3:0] hc(input logic [3:0] n);
`ifdef MOORE_SEQ_HITCOUNT_EN
        return n;
`else
        return 4'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".final"}, final_state, 0);
        check({tag, ".cnt"}, s3_count, 0);
        check({tag, ".x"}, x_out, 0);
        check({tag, ".rstn"}, fsm_reset_n, 0);
    endtask

    task automatic run(input string tag, input logic [7:0] pat,
                       input logic [1:0] exp_fs, input logic [3:0] exp_cnt);
        int         lat;
        logic [7:0] xs;
        lat     = 0;
        xs      = '0;
        pattern = pat;
        start   = 1'b1;
        do begin
            tick();
            lat++;
            start = 1'b0;
            if (lat == 1) begin
                check({tag, ".load_busy"}, busy, 1);
                check({tag, ".load_rstn"}, fsm_reset_n, 0);
                pattern = ~pat;
            end
            if (lat >= 2 && lat <= 9) xs[9-lat] = x_out;
        end while (!done && lat < 20);
        check({tag, ".latency"}, lat, 11);
        check({tag, ".xseq"}, xs, pat);
        check({tag, ".final"}, final_state, exp_fs);
        check({tag, ".s3cnt"}, s3_count, exp_cnt);
        check({tag, ".busy_done"}, busy, 0);
        tick();
        check({tag, ".idle_done"}, done, 0);
    endtask

    initial begin
        int first;
        int dones;
        int lat;
        reset   = 1'b1;
        start   = 1'b0;
        pattern = 8'h00;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();
        check("rstn_release", fsm_reset_n, 1);
        check("idle_busy", busy, 0);

        run("p00", 8'h00, 2'b11, hc(4'd3));
        run("pFF", 8'hFF, 2'b00, hc(4'd0));
        run("p7F", 8'h7F, 2'b10, hc(4'd0));
        run("p3F", 8'h3F, 2'b11, hc(4'd7));

        // start held high: one run, re-accept only after DONE's IDLE cycle
        pattern = 8'h00;
        start   = 1'b1;
        first   = 0;
        dones   = 0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i == 2) pattern = 8'hFF;
            if (done) begin
                dones++;
                if (first == 0) first = i;
            end
        end
        check("hold.first_done", first, 11);
        check("hold.done_count", dones, 1);
        check("hold.final", final_state, 2'b11);
        tick();
        check("hold.idle_busy", busy, 0);
        check("hold.idle_done", done, 0);
        tick();
        check("hold.reaccept", busy, 1);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        check("hold.second_lat", lat, 11);
        check("hold.second_final", final_state, 2'b00);
        tick();

        // reset during SHIFT
        pattern = 8'h00;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid.busy", busy, 1);
        reset = 1'b1;
        tick();
        check_reset_vals("mid");
        reset = 1'b0;
        tick();
        run("after", 8'h00, 2'b11, hc(4'd3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
